// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/wait/decode/exec/update sequencer driving PC controls and instruction-memory handshake
module fetch_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RE,
  input  logic        START,
  input  logic        MEM_ACK,
  input  logic        HALT_REQ,
  input  logic        EXE_DONE,
  input  logic        BR_TAKEN,
  output logic        PC_CS,
  output logic        PC_W,
  output logic        PC_R,
  output logic        PC_INC,
  output logic        PC_L,
  output logic        PC_RE,
  output logic        MEM_REQ,
  output logic        IR_LD,
  output logic        EXE_GO,
  output logic        BUSY,
  output logic        FAULT,
  output logic [2:0]  STATE,
  output logic [15:0] INSTR_CNT
);
  typedef enum logic [2:0] {
    st_idle, st_fetch, st_wait, st_decode, st_exec, st_update, st_halt, st_fault
  } state_t;
  state_t state, nxt;
  logic [3:0] wait_cnt;
  logic br, rd, up;
  always_ff @(posedge CLK) begin
    if (RE) begin
      state     <= st_idle;
      wait_cnt  <= '0;
      br        <= 1'b0;
      INSTR_CNT <= '0;
    end else begin
      state    <= nxt;
      wait_cnt <= state == st_wait ? wait_cnt + 4'd1 : '0;
      if (state == st_exec && EXE_DONE) br <= BR_TAKEN;
      if (state == st_update) INSTR_CNT <= INSTR_CNT + 16'd1;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      st_idle:   nxt = START ? st_fetch : st_idle;
      st_fetch:  nxt = st_wait;
      st_wait:   nxt = MEM_ACK ? st_decode : wait_cnt == 4'(TIMEOUT - 1) ? st_fault : st_wait;
      st_decode: nxt = HALT_REQ ? st_halt : st_exec;
      st_exec:   nxt = EXE_DONE ? st_update : st_exec;
      st_update: nxt = st_fetch;
      default:   nxt = state;
    endcase
  end
  assign rd        = state == st_fetch || state == st_wait;
  assign up        = state == st_update;
  assign PC_RE     = RE;
  assign PC_CS     = RE | rd | up;
  assign PC_W      = RE | up;
  assign PC_R      = !RE & rd;
  assign PC_INC    = !RE & up & !br;
  assign PC_L      = !RE & up & br;
  assign MEM_REQ   = !RE & rd;
  assign IR_LD     = !RE & state == st_wait & MEM_ACK;
  assign EXE_GO    = !RE & state == st_exec;
  assign BUSY      = !RE & state != st_idle & state != st_halt & state != st_fault;
  assign FAULT     = !RE & state == st_fault;
  assign STATE     = state;
endmodule
